// File: rtl/serial_magnitude_comparator_pkg.sv
// Shared encodings for the serial magnitude comparator: relation codes,
// FSM states and the helper that turns a chunk verdict into a relation code.
package comparator_pkg;

    localparam logic [1:0] REL_EQ = 2'b00;
    localparam logic [1:0] REL_GT = 2'b01;
    localparam logic [1:0] REL_LT = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPARE = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    function automatic logic [1:0] rel_code(input logic gt, input logic lt);
        if (gt) begin
            return REL_GT;
        end else if (lt) begin
            return REL_LT;
        end
        return REL_EQ;
    endfunction

endpackage

// File: rtl/serial_magnitude_comparator_if.sv
// Request/result bundle between a requester (master) and the comparator (slave).
interface serial_magnitude_comparator_if #(
    parameter int WIDTH = 8,
    parameter int STEP  = 1
);
    localparam int CW = $clog2(WIDTH / STEP + 1);

    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [1:0]       r;
    logic [CW-1:0]    cycles;

    modport master (
        output start, is_signed, a, b,
        input  busy, done, r, cycles
    );

    modport slave (
        input  start, is_signed, a, b,
        output busy, done, r, cycles
    );

endinterface

// File: rtl/serial_magnitude_comparator_chunk.sv
// Combinational unsigned compare of one STEP-bit chunk of each operand.
module cmp_chunk #(
    parameter int STEP = 1
) (
    input  logic [STEP-1:0] x,
    input  logic [STEP-1:0] y,
    output logic            gt,
    output logic            lt
);

    assign gt = (x > y);
    assign lt = (x < y);

endmodule

// File: rtl/serial_magnitude_comparator.sv
// Multi-cycle MSB-first magnitude comparator, STEP bits per cycle, early exit on
// the first differing chunk; signed mode biases both MSBs so the scan stays unsigned.
module serial_magnitude_comparator
    import comparator_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int STEP  = 1
) (
    input logic                          clk,
    input logic                          reset,
    serial_magnitude_comparator_if.slave bus
);

    localparam int NSTEPS = WIDTH / STEP;
    localparam int CW     = $clog2(NSTEPS + 1);
    localparam int IW     = (NSTEPS > 1) ? $clog2(NSTEPS) : 1;
    localparam logic [IW-1:0]    TOP_IDX  = IW'(NSTEPS - 1);
    localparam logic [WIDTH-1:0] MSB_MASK = {1'b1, {(WIDTH-1){1'b0}}};

    if (WIDTH < 2 || (WIDTH % STEP) != 0) begin : g_param_check
        $error("serial_magnitude_comparator: WIDTH must be >= 2 and a multiple of STEP");
    end

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [IW-1:0]    idx;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cycles_q;
    logic [1:0]       r_q;
    logic [STEP-1:0]  x_chunk;
    logic [STEP-1:0]  y_chunk;
    logic             gt;
    logic             lt;
    logic             last;
    logic             finish;

    assign x_chunk = a_q[idx*STEP +: STEP];
    assign y_chunk = b_q[idx*STEP +: STEP];
    assign last    = (idx == '0);
    assign finish  = gt || lt || last;

    cmp_chunk #(.STEP(STEP)) u_cmp (
        .x  (x_chunk),
        .y  (y_chunk),
        .gt (gt),
        .lt (lt)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:    if (bus.start) state_next = ST_COMPARE;
            ST_COMPARE: if (finish) state_next = ST_DONE;
            ST_DONE:    state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.busy = (state == ST_COMPARE);
        bus.done = (state == ST_DONE);
    end

    // Operands are captured once at accept; r/cycles only move on entry to DONE.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_q      <= '0;
            b_q      <= '0;
            idx      <= '0;
            cnt      <= '0;
            r_q      <= REL_EQ;
            cycles_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        a_q <= bus.is_signed ? (bus.a ^ MSB_MASK) : bus.a;
                        b_q <= bus.is_signed ? (bus.b ^ MSB_MASK) : bus.b;
                        idx <= TOP_IDX;
                        cnt <= CW'(1);
                    end
                end
                ST_COMPARE: begin
                    if (finish) begin
                        r_q      <= rel_code(gt, lt);
                        cycles_q <= cnt;
                    end else begin
                        idx <= idx - IW'(1);
                        cnt <= cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.r      = r_q;
    assign bus.cycles = cycles_q;

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Bench for serial_magnitude_comparator: directed cases plus randomized operations
// on W8/S1 and W8/S4 instances, checked against an arithmetic reference model.
module tb_serial_magnitude_comparator;

    logic clk;
    logic reset;
    int   vectors;
    int   errors;

    serial_magnitude_comparator_if #(.WIDTH(8), .STEP(1)) if0 ();
    serial_magnitude_comparator_if #(.WIDTH(8), .STEP(4)) if1 ();

    serial_magnitude_comparator #(.WIDTH(8), .STEP(1)) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (if0)
    );

    serial_magnitude_comparator #(.WIDTH(8), .STEP(4)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (if1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit sel, input logic st, input logic sg,
                         input logic [7:0] av, input logic [7:0] bv);
        if (sel) begin
            if1.start = st; if1.is_signed = sg; if1.a = av; if1.b = bv;
        end else begin
            if0.start = st; if0.is_signed = sg; if0.a = av; if0.b = bv;
        end
    endtask

    function automatic logic get_busy(input bit sel);
        return sel ? if1.busy : if0.busy;
    endfunction

    function automatic logic get_done(input bit sel);
        return sel ? if1.done : if0.done;
    endfunction

    function automatic logic [1:0] get_r(input bit sel);
        return sel ? if1.r : if0.r;
    endfunction

    function automatic logic [3:0] get_cycles(input bit sel);
        return sel ? {2'b00, if1.cycles} : if0.cycles;
    endfunction

    // Relation from plain (signed or unsigned) arithmetic; scan length from the
    // highest bit where the operands differ.
    task automatic model(input bit sel, input bit sg, input logic [7:0] av, input logic [7:0] bv,
                         output logic [1:0] r, output int n);
        int step;
        int nsteps;
        int p;
        logic [7:0] x;
        step   = sel ? 4 : 1;
        nsteps = 8 / step;
        if (sg ? ($signed(av) > $signed(bv)) : (av > bv)) r = 2'b01;
        else if (sg ? ($signed(av) < $signed(bv)) : (av < bv)) r = 2'b10;
        else r = 2'b00;
        x = av ^ bv;
        p = -1;
        while (x != 8'h00) begin
            x = x >> 1;
            p++;
        end
        n = (p < 0) ? nsteps : nsteps - p / step;
    endtask

    // One full operation; poke >= 0 re-asserts start (with other operands)
    // that many cycles into the scan.
    task automatic run_op(input bit sel, input bit sg, input logic [7:0] av, input logic [7:0] bv,
                          input int poke, input string tag);
        logic [1:0] er;
        int en;
        int lat;
        int busy_bad;
        model(sel, sg, av, bv, er, en);
        @(negedge clk);
        drive(sel, 1'b1, sg, av, bv);
        @(posedge clk);
        #1;
        lat = -1;
        busy_bad = 0;
        for (int k = 0; k < 20; k++) begin
            if (get_done(sel)) begin
                lat = k;
                break;
            end
            if (!get_busy(sel)) busy_bad++;
            if (k == poke) drive(sel, 1'b1, 1'b0, 8'h00, 8'hFF);
            else drive(sel, 1'b0, 1'($urandom), 8'($urandom), 8'($urandom));
            @(posedge clk);
            #1;
        end
        drive(sel, 1'b0, 1'b0, 8'h00, 8'h00);
        check($sformatf("%s.latency", tag), lat, en);
        check($sformatf("%s.busy_during_scan", tag), busy_bad, 0);
        check($sformatf("%s.busy_at_done", tag), get_busy(sel), 1'b0);
        check($sformatf("%s.r", tag), get_r(sel), er);
        check($sformatf("%s.cycles", tag), get_cycles(sel), en);
        @(posedge clk);
        #1;
        check($sformatf("%s.done_pulse", tag), get_done(sel), 1'b0);
        check($sformatf("%s.r_hold", tag), get_r(sel), er);
    endtask

    initial begin
        logic [7:0] ra;
        logic [7:0] rb;
        bit         rs;
        int         done_seen;
        vectors = 0;
        errors  = 0;
        drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);

        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            check($sformatf("reset%0d.busy", s), get_busy(s[0]), 1'b0);
            check($sformatf("reset%0d.done", s), get_done(s[0]), 1'b0);
            check($sformatf("reset%0d.r", s), get_r(s[0]), 2'b00);
            check($sformatf("reset%0d.cycles", s), get_cycles(s[0]), 4'd0);
        end
        @(negedge clk);
        reset = 1'b0;

        run_op(1'b0, 1'b0, 8'h02, 8'h01, -1, "s1_02_01");
        run_op(1'b0, 1'b0, 8'h80, 8'h00, -1, "s1_80_00_u");
        run_op(1'b0, 1'b1, 8'h80, 8'h00, -1, "s1_80_00_s");
        run_op(1'b0, 1'b0, 8'h5A, 8'h5A, -1, "s1_5a_eq");
        run_op(1'b1, 1'b0, 8'h37, 8'h3A, -1, "s4_37_3a");
        run_op(1'b1, 1'b1, 8'h7F, 8'h80, -1, "s4_7f_80_s");
        run_op(1'b1, 1'b0, 8'hC3, 8'hC3, -1, "s4_eq");
        run_op(1'b0, 1'b1, 8'hFF, 8'hFE, -1, "s1_ff_fe_s");

        for (int i = 0; i < 60; i++) begin
            ra = 8'($urandom);
            case ($urandom_range(0, 3))
                0:       rb = ra;
                1:       rb = {ra[7:4], 4'($urandom)};
                default: rb = 8'($urandom);
            endcase
            rs = 1'($urandom);
            run_op(i[0], rs, ra, rb, -1, $sformatf("rand%0d", i));
        end

        run_op(1'b0, 1'b0, 8'h02, 8'h01, 2, "start_during_busy");

        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 8'h02, 8'h01);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("abort.busy_before", get_busy(1'b0), 1'b1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("abort.busy", get_busy(1'b0), 1'b0);
        check("abort.done", get_done(1'b0), 1'b0);
        check("abort.r", get_r(1'b0), 2'b00);
        check("abort.cycles", get_cycles(1'b0), 4'd0);
        @(negedge clk);
        reset = 1'b0;
        done_seen = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (get_done(1'b0)) done_seen++;
        end
        check("abort.no_done", done_seen, 0);

        run_op(1'b0, 1'b1, 8'h10, 8'hF0, -1, "after_abort");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
